// File: rtl/shake_pkg.sv
// Shared types and constants for the SHAKE absorb/squeeze controller.
package shake_pkg;

    typedef enum logic {
        SHAKE128 = 1'b0,
        SHAKE256 = 1'b1
    } shake_mode_t;

    typedef enum logic [2:0] {
        IDLE,
        PERMUTE,
        SQUEEZE_LOAD,
        SQUEEZE,
        DONE
    } fsm_state_t;

    localparam int ROUNDS        = 24;
    localparam int RATE128_WORDS = 21;
    localparam int RATE256_WORDS = 17;

endpackage

// File: rtl/absorb_squeeze_fsm_if.sv
// Handshake bundle between the load stage, the Keccak state datapath, the PISO and the controller.
interface absorb_squeeze_fsm_if
    import shake_pkg::*;
#(
    parameter int OUT_LEN_W = 32
);
    logic                 input_buffer_ready;
    logic                 last_block_in_buffer;
    shake_mode_t          mode;
    logic [OUT_LEN_W-1:0] output_length;
    logic                 ready_in;
    logic                 buffer_consume;
    logic                 absorb_enable;
    logic                 round_enable;
    logic [4:0]           round_index;
    logic                 squeeze_load;
    logic                 out_shift;
    logic                 valid_out;
    logic                 last_output_word;
    logic                 state_clear;
    logic                 busy;

    // Controller side
    modport slave (
        input  input_buffer_ready, last_block_in_buffer, mode, output_length, ready_in,
        output buffer_consume, absorb_enable, round_enable, round_index, squeeze_load,
        output out_shift, valid_out, last_output_word, state_clear, busy
    );

    // Environment side
    modport master (
        output input_buffer_ready, last_block_in_buffer, mode, output_length, ready_in,
        input  buffer_consume, absorb_enable, round_enable, round_index, squeeze_load,
        input  out_shift, valid_out, last_output_word, state_clear, busy
    );
endinterface

// File: rtl/absorb_squeeze_fsm_out_len_counter.sv
// Tracks output words still owed for the current message: ceil(output_length/W),
// loaded when squeezing starts and decremented on every accepted word.
module absorb_squeeze_fsm_out_len_counter #(
    parameter int W         = 64,
    parameter int OUT_LEN_W = 32,
    parameter int CNT_W     = OUT_LEN_W - 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OUT_LEN_W-1:0] output_length,
    input  logic                 load,
    input  logic                 dec,
    output logic                 out_words_zero,
    output logic                 rem_one,
    output logic                 rem_zero
);
    localparam int SH = $clog2(W);

    logic [CNT_W-1:0] out_words;
    logic [CNT_W-1:0] remaining_q;

    // Quotient plus one if any partial word remains; CNT_W leaves room for the carry.
    assign out_words      = CNT_W'(output_length >> SH) + CNT_W'(|output_length[SH-1:0]);
    assign out_words_zero = (out_words == '0);
    assign rem_one        = (remaining_q == CNT_W'(1));
    assign rem_zero       = (remaining_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining_q <= '0;
        end else if (load) begin
            remaining_q <= out_words;
        end else if (dec && !rem_zero) begin
            remaining_q <= remaining_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/absorb_squeeze_fsm.sv
// SHAKE second-stage controller: absorbs buffered rate blocks, runs the round-per-cycle
// permutation and drives squeezing through the output PISO, including extra permutations.
module absorb_squeeze_fsm
    import shake_pkg::*;
#(
    parameter int W             = 64,
    parameter int ROUNDS        = shake_pkg::ROUNDS,
    parameter int OUT_LEN_W     = 32,
    parameter int RATE128_WORDS = shake_pkg::RATE128_WORDS,
    parameter int RATE256_WORDS = shake_pkg::RATE256_WORDS
) (
    input  logic                 clk,
    input  logic                 rst,
    absorb_squeeze_fsm_if.slave  bus
);
    fsm_state_t state_q, state_d;
    logic [4:0] round_cnt_q, round_cnt_d;
    logic [4:0] word_cnt_q, word_cnt_d;
    logic       last_flag_q, last_flag_d;
    logic       squeezing_q, squeezing_d;

    logic [4:0] rate_words;
    logic       last_round;
    logic       rem_load, out_words_zero, rem_one, rem_zero;

    logic       absorb, consume, round_en, load_sq, shift, valid, last_word, clear;
    logic [4:0] round_idx;

    assign rate_words = (bus.mode == SHAKE256) ? 5'(RATE256_WORDS) : 5'(RATE128_WORDS);
    assign last_round = (round_cnt_q == 5'(ROUNDS - 1));

    absorb_squeeze_fsm_out_len_counter #(
        .W         (W),
        .OUT_LEN_W (OUT_LEN_W)
    ) u_out_len (
        .clk            (clk),
        .rst            (rst),
        .output_length  (bus.output_length),
        .load           (rem_load),
        .dec            (shift),
        .out_words_zero (out_words_zero),
        .rem_one        (rem_one),
        .rem_zero       (rem_zero)
    );

    always_comb begin
        state_d     = state_q;
        round_cnt_d = round_cnt_q;
        word_cnt_d  = word_cnt_q;
        last_flag_d = last_flag_q;
        squeezing_d = squeezing_q;
        absorb      = 1'b0;
        consume     = 1'b0;
        round_en    = 1'b0;
        round_idx   = 5'd0;
        load_sq     = 1'b0;
        shift       = 1'b0;
        valid       = 1'b0;
        last_word   = 1'b0;
        clear       = 1'b0;
        rem_load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Gated by rst so nothing is consumed while reset is held.
                if (bus.input_buffer_ready && !rst) begin
                    absorb      = 1'b1;
                    consume     = 1'b1;
                    last_flag_d = bus.last_block_in_buffer;
                    round_cnt_d = 5'd0;
                    state_d     = PERMUTE;
                end
            end
            PERMUTE: begin
                round_en    = 1'b1;
                round_idx   = round_cnt_q;
                round_cnt_d = round_cnt_q + 5'd1;
                if (last_round) begin
                    round_cnt_d = 5'd0;
                    if (squeezing_q) begin
                        state_d = SQUEEZE_LOAD;
                    end else if (last_flag_q && out_words_zero) begin
                        state_d = DONE;
                    end else if (last_flag_q) begin
                        rem_load    = 1'b1;
                        squeezing_d = 1'b1;
                        state_d     = SQUEEZE_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            SQUEEZE_LOAD: begin
                load_sq    = 1'b1;
                word_cnt_d = 5'd0;
                state_d    = SQUEEZE;
            end
            SQUEEZE: begin
                valid     = !rem_zero;
                last_word = rem_one;
                if (rem_zero) begin
                    state_d = DONE;
                end else if (bus.ready_in) begin
                    shift      = 1'b1;
                    word_cnt_d = word_cnt_q + 5'd1;
                    if (rem_one) begin
                        state_d = DONE;
                    end else if (word_cnt_q == rate_words - 5'd1) begin
                        round_cnt_d = 5'd0;
                        state_d     = PERMUTE;
                    end
                end
            end
            DONE: begin
                clear       = 1'b1;
                squeezing_d = 1'b0;
                last_flag_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            round_cnt_q <= 5'd0;
            word_cnt_q  <= 5'd0;
            last_flag_q <= 1'b0;
            squeezing_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_cnt_q <= round_cnt_d;
            word_cnt_q  <= word_cnt_d;
            last_flag_q <= last_flag_d;
            squeezing_q <= squeezing_d;
        end
    end

    assign bus.buffer_consume   = consume;
    assign bus.absorb_enable    = absorb;
    assign bus.round_enable     = round_en;
    assign bus.round_index      = round_idx;
    assign bus.squeeze_load     = load_sq;
    assign bus.out_shift        = shift;
    assign bus.valid_out        = valid;
    assign bus.last_output_word = last_word;
    assign bus.state_clear      = clear;
    assign bus.busy             = (state_q != IDLE);

endmodule

// File: tb/tb_absorb_squeeze_fsm.sv
// Directed bench for absorb_squeeze_fsm: latency, multi-block, multi-rate squeeze, zero length,
// backpressure and mid-permutation reset.
module tb_absorb_squeeze_fsm;
    import shake_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    absorb_squeeze_fsm_if #(.OUT_LEN_W(32)) bus ();

    absorb_squeeze_fsm #(
        .W(64), .ROUNDS(24), .OUT_LEN_W(32), .RATE128_WORDS(21), .RATE256_WORDS(17)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int n_consume, n_absorb, n_round, n_load, n_valid, n_shift, n_clear, n_last, last_idx;
    int shifts_at_load2, rounds_at_load2;
    int bad_pulse, bad_ri, bad_shift, bad_last;
    int abs_cyc, first_rnd_cyc, last_rnd_cyc, load_cyc, valid_cyc, clear_cyc;
    logic p_consume, p_absorb, p_load, p_clear, p_ren;
    logic [4:0] p_idx;

    int timed_out, stall_bad;
    logic idle_busy;

    // Passive observer sampling mid-low-phase, after the driver has settled its inputs.
    always @(negedge clk) begin
        #3;
        cyc++;
        if (bus.buffer_consume) begin
            n_consume++;
            if (abs_cyc < 0) abs_cyc = cyc;
        end
        if (bus.absorb_enable) n_absorb++;
        if ((bus.buffer_consume && p_consume) || (bus.absorb_enable && p_absorb) ||
            (bus.squeeze_load && p_load) || (bus.state_clear && p_clear)) bad_pulse++;
        if (bus.round_enable) begin
            n_round++;
            if (first_rnd_cyc < 0) first_rnd_cyc = cyc;
            last_rnd_cyc = cyc;
            if (bus.round_index !== (p_ren ? p_idx + 5'd1 : 5'd0)) bad_ri++;
        end else if (bus.round_index !== 5'd0) begin
            bad_ri++;
        end
        if (bus.squeeze_load) begin
            n_load++;
            if (load_cyc < 0) load_cyc = cyc;
            if (n_load == 2) begin
                shifts_at_load2 = n_shift;
                rounds_at_load2 = n_round;
            end
        end
        if (bus.valid_out) begin
            n_valid++;
            if (valid_cyc < 0) valid_cyc = cyc;
        end
        if (bus.out_shift !== (bus.valid_out && bus.ready_in)) bad_shift++;
        if (bus.last_output_word && !bus.valid_out) bad_last++;
        if (bus.out_shift) begin
            n_shift++;
            if (bus.last_output_word) begin
                n_last++;
                last_idx = n_shift;
            end
        end
        if (bus.state_clear) begin
            n_clear++;
            if (clear_cyc < 0) clear_cyc = cyc;
        end
        p_consume = bus.buffer_consume;
        p_absorb  = bus.absorb_enable;
        p_load    = bus.squeeze_load;
        p_clear   = bus.state_clear;
        p_ren     = bus.round_enable;
        p_idx     = bus.round_index;
    end

    task automatic clear_stats();
        n_consume = 0; n_absorb = 0; n_round = 0; n_load = 0; n_valid = 0; n_shift = 0;
        n_clear = 0; n_last = 0; last_idx = 0; shifts_at_load2 = -1; rounds_at_load2 = -1;
        bad_pulse = 0; bad_ri = 0; bad_shift = 0; bad_last = 0;
        abs_cyc = -1; first_rnd_cyc = -1; last_rnd_cyc = -1; load_cyc = -1; valid_cyc = -1;
        clear_cyc = -1; timed_out = 0; stall_bad = 0;
    endtask

    // Plays the load stage and the downstream sink until the message completes.
    task automatic run_msg(input shake_mode_t m, input logic [31:0] len, input int nblk,
                           input int stall_at);
        int blocks_left = nblk;
        int loc_shifts = 0;
        int stall_used = 0;
        bit finished = 0;
        clear_stats();
        bus.mode = m;
        bus.output_length = len;
        for (int c = 0; c < 3000 && !finished; c++) begin
            @(negedge clk);
            bus.input_buffer_ready   = (blocks_left > 0);
            bus.last_block_in_buffer = (blocks_left == 1);
            bus.ready_in = !(stall_at >= 0 && loc_shifts == stall_at && stall_used < 5);
            #1;
            if (bus.buffer_consume) blocks_left--;
            if (bus.valid_out && !bus.ready_in) begin
                stall_used++;
                if (bus.out_shift || bus.last_output_word) stall_bad++;
            end
            if (bus.out_shift) loc_shifts++;
            if (bus.state_clear) finished = 1;
        end
        if (!finished) timed_out = 1;
        @(negedge clk);
        bus.input_buffer_ready = 1'b0;
        bus.ready_in = 1'b1;
        #1;
        idle_busy = bus.busy;
        #3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.input_buffer_ready = 1'b1;
        bus.last_block_in_buffer = 1'b1;
        bus.mode = SHAKE128;
        bus.output_length = 32'd64;
        bus.ready_in = 1'b1;
        #1;
        checks++;
        if ({bus.buffer_consume, bus.absorb_enable, bus.round_enable, bus.round_index,
             bus.squeeze_load, bus.out_shift, bus.valid_out, bus.last_output_word,
             bus.state_clear, bus.busy} !== 14'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {bus.buffer_consume, bus.absorb_enable,
                     bus.round_enable, bus.round_index, bus.squeeze_load, bus.out_shift,
                     bus.valid_out, bus.last_output_word, bus.state_clear, bus.busy});
        end
        repeat (2) @(negedge clk);
        bus.input_buffer_ready = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE);
        end
        #3;
    endtask

    task automatic test_single_block();
        run_msg(SHAKE128, 32'd64, 1, -1);
        checks++; if (timed_out !== 0) begin failures++; $display("FAIL t1_timeout got=%0d exp=0", timed_out); end
        checks++; if (n_consume !== 1) begin failures++; $display("FAIL t1_consume got=%0d exp=1", n_consume); end
        checks++; if (first_rnd_cyc - abs_cyc !== 1) begin failures++; $display("FAIL t1_first_round got=%0d exp=1", first_rnd_cyc - abs_cyc); end
        checks++; if (last_rnd_cyc - abs_cyc !== 24) begin failures++; $display("FAIL t1_last_round got=%0d exp=24", last_rnd_cyc - abs_cyc); end
        checks++; if (n_round !== 24) begin failures++; $display("FAIL t1_rounds got=%0d exp=24", n_round); end
        checks++; if (load_cyc - abs_cyc !== 25) begin failures++; $display("FAIL t1_load got=%0d exp=25", load_cyc - abs_cyc); end
        checks++; if (valid_cyc - abs_cyc !== 26) begin failures++; $display("FAIL t1_valid got=%0d exp=26", valid_cyc - abs_cyc); end
        checks++; if (n_last !== 1 || last_idx !== 1) begin failures++; $display("FAIL t1_last_word got=%0d/%0d exp=1/1", n_last, last_idx); end
        checks++; if (clear_cyc - abs_cyc !== 27) begin failures++; $display("FAIL t1_clear got=%0d exp=27", clear_cyc - abs_cyc); end
        checks++; if (idle_busy !== 1'b0) begin failures++; $display("FAIL t1_idle_busy got=%0d exp=0", idle_busy); end
        checks++; if (bad_ri !== 0) begin failures++; $display("FAIL t1_round_index got=%0d exp=0", bad_ri); end
    endtask

    task automatic test_multi_block();
        run_msg(SHAKE256, 32'd256, 3, -1);
        checks++; if (timed_out !== 0) begin failures++; $display("FAIL t2_timeout got=%0d exp=0", timed_out); end
        checks++; if (n_consume !== 3 || n_absorb !== 3) begin failures++; $display("FAIL t2_consume got=%0d/%0d exp=3/3", n_consume, n_absorb); end
        checks++; if (n_round !== 72) begin failures++; $display("FAIL t2_rounds got=%0d exp=72", n_round); end
        checks++; if (n_shift !== 4) begin failures++; $display("FAIL t2_words got=%0d exp=4", n_shift); end
        checks++; if (n_last !== 1 || last_idx !== 4) begin failures++; $display("FAIL t2_last_word got=%0d/%0d exp=1/4", n_last, last_idx); end
        checks++; if (bad_pulse !== 0) begin failures++; $display("FAIL t2_pulse_width got=%0d exp=0", bad_pulse); end
    endtask

    task automatic test_multi_squeeze();
        run_msg(SHAKE256, 32'd1200, 1, -1);
        checks++; if (timed_out !== 0) begin failures++; $display("FAIL t3_timeout got=%0d exp=0", timed_out); end
        checks++; if (n_shift !== 19 || n_valid !== 19) begin failures++; $display("FAIL t3_words got=%0d/%0d exp=19/19", n_shift, n_valid); end
        checks++; if (n_load !== 2) begin failures++; $display("FAIL t3_loads got=%0d exp=2", n_load); end
        checks++; if (shifts_at_load2 !== 17) begin failures++; $display("FAIL t3_first_block_words got=%0d exp=17", shifts_at_load2); end
        checks++; if (rounds_at_load2 !== 48) begin failures++; $display("FAIL t3_extra_rounds got=%0d exp=48", rounds_at_load2); end
        checks++; if (n_last !== 1 || last_idx !== 19) begin failures++; $display("FAIL t3_last_word got=%0d/%0d exp=1/19", n_last, last_idx); end
        checks++; if (bad_ri !== 0 || bad_last !== 0) begin failures++; $display("FAIL t3_index_last got=%0d/%0d exp=0/0", bad_ri, bad_last); end
    endtask

    task automatic test_zero_length();
        run_msg(SHAKE128, 32'd0, 1, -1);
        checks++; if (timed_out !== 0) begin failures++; $display("FAIL t4_timeout got=%0d exp=0", timed_out); end
        checks++; if (n_load !== 0 || n_valid !== 0) begin failures++; $display("FAIL t4_no_squeeze got=%0d/%0d exp=0/0", n_load, n_valid); end
        checks++; if (n_round !== 24) begin failures++; $display("FAIL t4_rounds got=%0d exp=24", n_round); end
        checks++; if (clear_cyc - last_rnd_cyc !== 1) begin failures++; $display("FAIL t4_clear_after got=%0d exp=1", clear_cyc - last_rnd_cyc); end
    endtask

    task automatic test_backpressure();
        run_msg(SHAKE128, 32'd192, 1, 1);
        checks++; if (timed_out !== 0) begin failures++; $display("FAIL t5_timeout got=%0d exp=0", timed_out); end
        checks++; if (n_shift !== 3) begin failures++; $display("FAIL t5_shifts got=%0d exp=3", n_shift); end
        checks++; if (n_valid !== 8) begin failures++; $display("FAIL t5_valid_cycles got=%0d exp=8", n_valid); end
        checks++; if (stall_bad !== 0 || bad_shift !== 0) begin failures++; $display("FAIL t5_stall got=%0d/%0d exp=0/0", stall_bad, bad_shift); end
        checks++; if (n_last !== 1 || last_idx !== 3) begin failures++; $display("FAIL t5_last_word got=%0d/%0d exp=1/3", n_last, last_idx); end
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        clear_stats();
        bus.mode = SHAKE128;
        bus.output_length = 32'd64;
        bus.ready_in = 1'b1;
        @(negedge clk);
        bus.input_buffer_ready = 1'b1;
        bus.last_block_in_buffer = 1'b1;
        for (int c = 0; c < 60 && !hit; c++) begin
            @(negedge clk);
            bus.input_buffer_ready = 1'b0;
            #1;
            if (bus.round_enable && bus.round_index == 5'd10) hit = 1;
        end
        checks++; if (!hit) begin failures++; $display("FAIL t6_reach_round10 got=0 exp=1"); end
        rst = 1'b1;
        bus.input_buffer_ready = 1'b1;
        #1;
        checks++;
        if ({bus.buffer_consume, bus.absorb_enable, bus.round_enable, bus.round_index,
             bus.squeeze_load, bus.out_shift, bus.valid_out, bus.last_output_word,
             bus.state_clear, bus.busy} !== 14'd0) begin
            failures++;
            $display("FAIL t6_reset_outputs got=%b exp=0", {bus.buffer_consume, bus.absorb_enable,
                     bus.round_enable, bus.round_index, bus.squeeze_load, bus.out_shift,
                     bus.valid_out, bus.last_output_word, bus.state_clear, bus.busy});
        end
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL t6_reset_state got=%0d exp=%0d", dut.state_q, IDLE); end
        @(negedge clk);
        bus.input_buffer_ready = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        checks++; if (n_clear !== 0 || n_consume !== 1) begin failures++; $display("FAIL t6_aborted got=%0d/%0d exp=0/1", n_clear, n_consume); end
        run_msg(SHAKE128, 32'd64, 1, -1);
        checks++; if (timed_out !== 0) begin failures++; $display("FAIL t6_timeout got=%0d exp=0", timed_out); end
        checks++; if (first_rnd_cyc - abs_cyc !== 1 || bad_ri !== 0) begin failures++; $display("FAIL t6_restart got=%0d/%0d exp=1/0", first_rnd_cyc - abs_cyc, bad_ri); end
        checks++; if (n_round !== 24 || n_clear !== 1) begin failures++; $display("FAIL t6_after_reset got=%0d/%0d exp=24/1", n_round, n_clear); end
    endtask

    initial begin
        clear_stats();
        p_consume = 0; p_absorb = 0; p_load = 0; p_clear = 0; p_ren = 0; p_idx = 5'd0;
        test_reset();
        test_single_block();
        test_multi_block();
        test_multi_squeeze();
        test_zero_length();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
